// File: rtl/vec_req_responder.sv
// Purpose: memory-side responder; round-robin arbitration across N requestors into a 2^AW x DW register file, with the response routed back to the requestor that issued it.
// Latency: a request accepted at edge t is presented on resp_* during the cycle after edge t+LAT-1. Throughput is one request per cycle.
// Backpressure: responses are never stalled. Only the granted requestor sees req_ready; the others hold their request until granted.
// Ports: clk/reset_n (async active-low); req_valid/req_we [N] and req_addr/req_wdata (packed N slices) in;
//        req_ready [N] one-hot grant (combinational); resp_valid [N] one-hot, resp_data [DW], busy out.
module vec_req_responder #(
  parameter int N   = 4,
  parameter int AW  = 4,
  parameter int DW  = 8,
  parameter int LAT = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [N-1:0]    req_we,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*DW-1:0] req_wdata,
  output logic [N-1:0]    resp_valid,
  output logic [DW-1:0]   resp_data,
  output logic            busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] r_ptr;
  logic [DW-1:0] r_mem [2**AW];

  // Response pipeline; stage LAT-1 drives the outputs.
  logic [LAT-1:0] r_vld;
  logic [IW-1:0]  r_id  [LAT];
  logic [DW-1:0]  r_dat [LAT];

  logic          w_gnt_vld;
  logic [IW-1:0] w_gnt_idx;
  logic [IW-1:0] w_cand;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_resp_dat;

  // Scan from ptr upward and wrap. The loop runs from the farthest
  // candidate down to the nearest, so the nearest valid requestor wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = IW'((int'(r_ptr) + k) % N);
      if (req_valid[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_gnt_vld) req_ready[w_gnt_idx] = 1'b1;
  end

  assign w_we       = req_we[w_gnt_idx];
  assign w_addr     = req_addr[w_gnt_idx*AW +: AW];
  assign w_wdata    = req_wdata[w_gnt_idx*DW +: DW];
  // A write echoes its own data. A read returns the contents from before this edge.
  assign w_resp_dat = w_we ? w_wdata : r_mem[w_addr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (w_gnt_vld) begin
      if (w_gnt_idx == IW'(N - 1)) r_ptr <= '0;
      else                         r_ptr <= w_gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int a = 0; a < 2**AW; a++) r_mem[a] <= '0;
    end else if (w_gnt_vld && w_we) begin
      r_mem[w_addr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
      for (int s = 0; s < LAT; s++) begin
        r_id[s]  <= '0;
        r_dat[s] <= '0;
      end
    end else begin
      r_vld[0] <= w_gnt_vld;
      r_id[0]  <= w_gnt_idx;
      r_dat[0] <= w_resp_dat;
      for (int s = 1; s < LAT; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_id[s]  <= r_id[s-1];
        r_dat[s] <= r_dat[s-1];
      end
    end
  end

  always_comb begin
    resp_valid = '0;
    if (r_vld[LAT-1]) resp_valid[r_id[LAT-1]] = 1'b1;
  end

  assign resp_data = r_vld[LAT-1] ? r_dat[LAT-1] : '0;
  assign busy      = |r_vld;

endmodule

// File: tb/tb_vec_req_responder.sv
// Purpose: bench for vec_req_responder. A transaction-level reference model checks the DUT every cycle, and directed steps add scenario-specific checks.
// Latency: per-cycle checks at negedge+1, using a model of response timing keyed by acceptance edge.
// Backpressure: modelled requestors hold valid and payload until they are granted.
module tb_vec_req_responder;

  localparam int N   = 4;
  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    resp_valid;
  logic [DW-1:0]   resp_data;
  logic            busy;

  always #5 clk = ~clk;

  vec_req_responder #(.N(N), .AW(AW), .DW(DW), .LAT(LAT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Requestor state.
  bit pend   [N];
  bit keep   [N];
  bit p_we   [N];
  int p_addr [N];
  int p_dat  [N];

  // Reference model: arbitration pointer, memory contents, and the responses keyed by the edge that accepted them.
  int mptr;
  int mmem [16];
  int ecount;
  int rsp_id  [int];
  int rsp_dat [int];

  logic [N-1:0]  last_rdy;
  logic [N-1:0]  last_rv;
  logic [DW-1:0] last_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_grant();
    for (int k = 0; k < N; k++)
      if (pend[(mptr + k) % N]) return (mptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    mptr = 0;
    for (int a = 0; a < 16; a++) mmem[a] = 0;
    rsp_id.delete();
    rsp_dat.delete();
  endtask

  task automatic set_req(input int p, input bit we, input int addr, input int dat);
    pend[p]   = 1'b1;
    p_we[p]   = we;
    p_addr[p] = addr;
    p_dat[p]  = dat;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      keep[i] = 1'b0;
    end
  endtask

  // One clock cycle: drive inputs, check the combinational grant and the registered outputs, then model the edge.
  task automatic step();
    int           g;
    int           key;
    logic [N-1:0] exp_rv;
    int           exp_rd;
    bit           exp_busy;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = pend[i];
      req_we[i]               = p_we[i];
      req_addr[i*AW +: AW]    = AW'(p_addr[i]);
      req_wdata[i*DW +: DW]   = DW'(p_dat[i]);
    end
    #1;
    g        = model_grant();
    last_rdy = req_ready;
    last_rv  = resp_valid;
    last_rd  = resp_data;
    check("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
    key    = ecount - LAT + 1;
    exp_rv = '0;
    exp_rd = 0;
    if (rsp_id.exists(key)) begin
      exp_rv = N'(1 << rsp_id[key]);
      exp_rd = rsp_dat[key];
    end
    check("resp_valid", resp_valid, exp_rv);
    check("resp_data", resp_data, exp_rd);
    exp_busy = 1'b0;
    for (int e = key; e <= ecount; e++)
      if (rsp_id.exists(e)) exp_busy = 1'b1;
    check("busy", busy, exp_busy);
    @(posedge clk);
    ecount++;
    if (reset_n && g >= 0) begin
      rsp_id[ecount]  = g;
      rsp_dat[ecount] = p_we[g] ? p_dat[g] : mmem[p_addr[g]];
      if (p_we[g]) mmem[p_addr[g]] = p_dat[g];
      mptr = (g + 1) % N;
      if (!keep[g]) pend[g] = 1'b0;
    end
    #1;
  endtask

  initial begin
    reset_n   = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    ecount    = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; keep[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = 0; p_dat[i] = 0;
    end
    model_reset();
    #2 reset_n = 1'b0;

    // Reset held with every requestor valid: no acceptance and quiet outputs.
    for (int i = 0; i < N; i++) set_req(i, 1'b0, i, 0);
    repeat (3) step();
    check("rst_resp_valid", last_rv, 0);
    check("rst_busy", busy, 0);

    // Fairness: all four requestors valid continuously.
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) keep[i] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("fair_grant", last_rdy, 1 << (i % 4));
      if (i >= 2) check("fair_resp_id", last_rv, 1 << ((i - 2) % 4));
    end
    clear_reqs();
    repeat (3) step();

    // Wrap/skip: grant port 2 to move ptr to 3, then only ports 1 and 3 are valid.
    set_req(2, 1'b0, 1, 0);
    step();
    check("skip_pre", last_rdy, 4'b0100);
    set_req(1, 1'b0, 2, 0);
    set_req(3, 1'b0, 3, 0);
    keep[1] = 1'b1;
    keep[3] = 1'b1;
    step(); check("wrap_g3a", last_rdy, 4'b1000);
    step(); check("wrap_g1",  last_rdy, 4'b0010);
    step(); check("wrap_g3b", last_rdy, 4'b1000);
    clear_reqs();
    repeat (3) step();

    // Write then read the same address on the next edge.
    set_req(2, 1'b1, 7, 8'hA5);
    step();
    check("wr_grant", last_rdy, 4'b0100);
    set_req(0, 1'b0, 7, 0);
    step();
    step();
    check("wr_resp_valid", last_rv, 4'b0100);
    check("wr_resp_data",  last_rd, 8'hA5);
    step();
    check("raw_resp_valid", last_rv, 4'b0001);
    check("raw_resp_data",  last_rd, 8'hA5);
    repeat (2) step();

    // Reset during flight: two writes accepted, then reset asserted mid-cycle.
    set_req(0, 1'b1, 5, 8'h3C);
    set_req(1, 1'b1, 6, 8'h77);
    step();
    step();
    reset_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rv",   resp_valid, 0);
    check("mid_rst_rd",   resp_data, 0);
    repeat (2) step();
    reset_n = 1'b1;

    // Unwritten read after reset.
    set_req(1, 1'b0, 3, 0);
    step();
    step();
    step();
    check("unwr_resp_valid", last_rv, 4'b0010);
    check("unwr_resp_data",  last_rd, 0);

    // Previously written addresses read back as zero after reset.
    set_req(0, 1'b0, 5, 0);
    set_req(2, 1'b0, 6, 0);
    repeat (5) step();

    // Randomized traffic over a small address range, so read-after-write cases are frequent.
    repeat (400) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && ($urandom % 2 == 1))
          set_req(i, 1'($urandom % 2), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      step();
    end
    repeat (N + LAT + 2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_req_responder.md
# vec_req_responder

Memory-side responder for the N-port requestor vector: arbitrates round-robin among requestor `req` channels, accepts at most one request per cycle into a small register-file memory, and returns each response to the originating requestor after a fixed pipeline latency. It is the far end of the per-requestor `req_valid`/`req_ready` handshake and drives the per-requestor `resp` channel back.

## Interface
- `N`, 4: number of requestor ports (2..8).
- `AW`, 4: address width; memory depth is 2^AW words.
- `DW`, 8: data width.
- `LAT`, 2: response latency in cycles after the accepting edge (1..4).
- `clk` in 1: single clock, all state on rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `req_valid` in N: bit i = requestor i has a request.
- `req_ready` out N: one-hot grant, bit i = request i accepted this edge.
- `req_we` in N: bit i = request i is a write.
- `req_addr` in N*AW: slice i = address of request i.
- `req_wdata` in N*DW: slice i = write data of request i.
- `resp_valid` out N: one-hot, bit i = response for requestor i this cycle.
- `resp_data` out DW: read data or echoed write data; 0 when no response.
- `busy` out 1: any request in flight in the response pipeline.

## Operation
- Arbitration: round-robin pointer `ptr` (0..N-1, reset 0). Grant goes to the first i with `req_valid[i]` scanning ptr, ptr+1, …, wrapping mod N. `req_ready` is combinational from `req_valid` and `ptr`, at most one bit set, all zero when no valid. `req_ready[i]` never asserts without `req_valid[i]`.
- On an accepting edge with grant g, `ptr` becomes (g+1) mod N, with g=N-1 wrapping to 0. Without a grant, `ptr` holds.
- No backpressure on responses. Responders always accept, so a valid request is granted within N cycles. Requestors hold valid/payload until granted.
- Write (`req_we[g]`=1): mem[addr] <= wdata at the accepting edge. The response carries wdata.
- Read: data = mem[addr] sampled at the accepting edge, pre-edge contents. Only one request is accepted per edge, so there is no same-edge read/write conflict.
- Response pipeline: LAT stages of {valid, id (log2 N bits), data}, shifted every cycle. Stage 0 is loaded at the accepting edge, with valid=0 when there is no grant. The output is taken from stage LAT-1.
- `resp_valid` is the one-hot of the last stage id, gated by its valid. `resp_data` is the last-stage data when valid, else 0.
- `busy` is the OR of all stage valids.
- Memory contents reset to 0.

## Timing
- Reset (async assert, any time): `ptr`=0, all stage valids=0, memory cleared.
  - `resp_valid`=0, `resp_data`=0, `busy`=0 immediately on assertion.
  - `req_ready` stays combinational from `req_valid` but no acceptance occurs while reset is held.
  - In-flight responses are discarded, never delivered.
- Deassertion is synchronised externally. The first accepting edge is the first rising edge with `reset_n`=1.
- Latency: a request accepted at edge t produces `resp_valid` high for exactly the one cycle following edge t+LAT-1. With LAT=1, the response appears in the cycle right after acceptance.
- Throughput is one request per cycle. Back-to-back acceptances give back-to-back responses in acceptance order.
- Read-after-write: a read accepted at edge t+1 to the address written at edge t returns the new data.
- A requestor may be granted in consecutive cycles only if no other requestor is valid.

## Test plan
- Reset: hold `reset_n`=0 with all `req_valid`=1111 → `resp_valid`=0, `resp_data`=0, `busy`=0. After release, the first grant is `req_ready`=0001.
- Fairness: all four valid continuously for 8 cycles → grants 0001,0010,0100,1000,0001,… Responses arrive with ids 0,1,2,3,0,… each 2 cycles after their grant.
- Wrap/skip: `ptr`=3 with only requestors 1 and 3 valid → grant 3, then 1 (wrapping), then 3.
- Write then read: port 2 writes 0xA5 to addr 7 at edge t; port 0 reads addr 7 at edge t+1 → `resp_valid`=0100 with data 0xA5 after edge t+1, then `resp_valid`=0001 with data 0xA5 after edge t+2.
- Unwritten read: port 1 reads addr 3 after reset → `resp_data`=0x00 with `resp_valid`=0010.
- Reset mid-flight: accept 2 requests, assert `reset_n`=0 one cycle later → no `resp_valid` ever appears, `busy` drops immediately, and a subsequent read of any previously written address returns 0.
